// File: rtl/potato_lcd_scan.sv
// Frame reader: walks the pixel source over WxH and streams a CASET/RASET/RAMWR preamble plus pixels to an SPI LCD.
// Optional POTATO_LCD_RGB_SWAP_EN swaps the red/blue fields of each latched pixel.
module potato_lcd_scan #(
    parameter int W          = 132,
    parameter int H          = 162,
    parameter int CLK_DIV    = 2,
    parameter int RD_LAT     = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    input  logic [15:0] ram_data,
    output logic        lcd_cs_n,
    output logic        lcd_sclk,
    output logic        lcd_mosi,
    output logic        lcd_dc,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_PIX_ADDR, S_PIX_WAIT, S_PIX_SHIFT, S_GAP} state_e;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RD_LAT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(2 * CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d, sr_q, sr_d;
    logic        sclk_q, sclk_d, dc_q, dc_d;
    logic [3:0]  bit_q, bit_d, byte_q, byte_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [15:0] pix;
    logic        shifting, tick, bit_done, unit_done, last_byte, last_x, last_y;
    logic        wait_done, gap_done, go;

    function automatic logic [7:0] cmd_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h2A;
            4'd4:    return 8'(W - 1);
            4'd5:    return 8'h2B;
            4'd9:    return 8'(H - 1);
            4'd10:   return 8'h2C;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic cmd_dc(input logic [3:0] i);
        return !(i == 4'd0 || i == 4'd5 || i == 4'd10);
    endfunction

`ifdef POTATO_LCD_RGB_SWAP_EN
    assign pix = {ram_data[4:0], ram_data[10:5], ram_data[15:11]};
`else
    assign pix = ram_data;
`endif

    assign shifting  = (state_q == S_CMD) || (state_q == S_PIX_SHIFT);
    assign tick      = (div_q == DIV_LAST);
    // A bit finishes at the end of its sclk-high half.
    assign bit_done  = shifting && tick && sclk_q;
    assign unit_done = bit_done && (bit_q == ((state_q == S_CMD) ? 4'd7 : 4'd15));
    assign last_byte = (byte_q == 4'd10);
    assign last_x    = (x_q == 8'(W - 1));
    assign last_y    = (y_q == 8'(H - 1));
    assign wait_done = (state_q == S_PIX_WAIT) && (cnt_q == WAIT_LAST);
    assign gap_done  = (state_q == S_GAP) && (cnt_q == GAP_LAST);
    assign go        = start || (CONTINUOUS != 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (go) state_d = S_CMD;
            S_CMD:       if (unit_done && last_byte) state_d = S_PIX_ADDR;
            S_PIX_ADDR:  state_d = S_PIX_WAIT;
            S_PIX_WAIT:  if (wait_done) state_d = S_PIX_SHIFT;
            S_PIX_SHIFT: if (unit_done) state_d = (last_x && last_y) ? S_GAP : S_PIX_ADDR;
            S_GAP:       if (gap_done) state_d = (CONTINUOUS != 0) ? S_CMD : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lcd_cs_n   = (state_q == S_IDLE) || (state_q == S_GAP);
        lcd_sclk   = sclk_q;
        lcd_mosi   = shifting && sr_q[15];
        lcd_dc     = dc_q;
        busy       = (state_q != S_IDLE);
        frame_done = gap_done;
        ram_addr_x = x_q;
        ram_addr_y = y_q;
    end

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        sr_d   = sr_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        dc_d   = dc_q;
        cnt_d  = cnt_q;
        x_d    = x_q;
        y_d    = y_q;
        if (shifting) begin
            div_d  = tick ? 16'd0 : div_q + 16'd1;
            sclk_d = tick ? !sclk_q : sclk_q;
            if (bit_done) begin
                sr_d  = {sr_q[14:0], 1'b0};
                bit_d = bit_q + 4'd1;
            end
        end
        // Next byte is loaded on the same edge the last bit ends, so bytes run back to back.
        if ((state_q == S_IDLE && go) || (gap_done && CONTINUOUS != 0)) begin
            sr_d   = {cmd_byte(4'd0), 8'h00};
            dc_d   = cmd_dc(4'd0);
            byte_d = 4'd0;
            bit_d  = 4'd0;
            div_d  = 16'd0;
            sclk_d = 1'b0;
        end
        case (state_q)
            S_CMD: if (unit_done) begin
                bit_d = 4'd0;
                if (last_byte) begin
                    byte_d = 4'd0;
                    cnt_d  = 16'd0;
                end else begin
                    byte_d = byte_q + 4'd1;
                    sr_d   = {cmd_byte(byte_q + 4'd1), 8'h00};
                    dc_d   = cmd_dc(byte_q + 4'd1);
                end
            end
            S_PIX_ADDR: cnt_d = 16'd0;
            S_PIX_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (wait_done) begin
                    sr_d   = pix;
                    dc_d   = 1'b1;
                    bit_d  = 4'd0;
                    div_d  = 16'd0;
                    sclk_d = 1'b0;
                    cnt_d  = 16'd0;
                end
            end
            S_PIX_SHIFT: if (unit_done) begin
                bit_d = 4'd0;
                cnt_d = 16'd0;
                if (last_x) begin
                    x_d = 8'd0;
                    y_d = last_y ? 8'd0 : y_q + 8'd1;
                    if (last_y) dc_d = 1'b0;
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            S_GAP: cnt_d = gap_done ? 16'd0 : cnt_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            sr_q   <= '0;
            sclk_q <= 1'b0;
            dc_q   <= 1'b0;
            bit_q  <= '0;
            byte_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            sclk_q <= sclk_d;
            dc_q   <= dc_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end
endmodule

// File: tb/tb_potato_lcd_scan.sv
// Directed bench for potato_lcd_scan: decodes the SPI stream and compares against hand-computed bytes/pixels.
module tb_potato_lcd_scan;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [7:0]  ax, ay, cax, cay;
    logic [15:0] rd;
    logic        cs_n, sclk, mosi, dc, busy, done;
    logic        c_cs_n, c_sclk, c_mosi, c_dc, c_busy, c_done;
    logic        pat;
    logic [15:0] apipe [2];

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    potato_lcd_scan #(.W(2), .H(2), .CLK_DIV(1), .RD_LAT(2), .CONTINUOUS(0)) dut (
        .clk(clk), .rst(rst_n), .start(start), .ram_addr_x(ax), .ram_addr_y(ay), .ram_data(rd),
        .lcd_cs_n(cs_n), .lcd_sclk(sclk), .lcd_mosi(mosi), .lcd_dc(dc), .busy(busy), .frame_done(done));

    potato_lcd_scan #(.W(2), .H(2), .CLK_DIV(2), .RD_LAT(1), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst(rst_n), .start(1'b0), .ram_addr_x(cax), .ram_addr_y(cay), .ram_data(16'h5A5A),
        .lcd_cs_n(c_cs_n), .lcd_sclk(c_sclk), .lcd_mosi(c_mosi), .lcd_dc(c_dc), .busy(c_busy), .frame_done(c_done));

    // Pixel source with 2-cycle read latency returning {y,x,A5}
    always @(posedge clk) begin
        apipe[0] <= {ax, ay};
        apipe[1] <= apipe[0];
    end
    assign rd = pat ? 16'hF800 : {apipe[1][3:0], apipe[1][11:8], 8'hA5};

    logic [1:0] cap [$];
    logic       prev_sclk = 1'b0;
    int         done_cnt = 0;
    always @(negedge clk) begin
        if (!prev_sclk && sclk && !cs_n) cap.push_back({dc, mosi});
        prev_sclk <= sclk;
        if (done) done_cnt <= done_cnt + 1;
    end

    int  c_run = 0, c_done_cnt = 0;
    bit  c_seen_low = 0;
    int  c_gaps [$];
    always @(negedge clk) begin
        if (!rst_n) begin
            c_seen_low <= 0; c_run <= 0;
        end else if (c_cs_n) begin
            c_run <= c_run + 1;
        end else begin
            if (c_seen_low && c_run > 0) c_gaps.push_back(c_run);
            c_seen_low <= 1; c_run <= 0;
        end
        if (rst_n && c_done) c_done_cnt <= c_done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dec(input logic [1:0] q [$], input int pos, input int nb);
        logic [15:0] w = '0;
        if (pos + nb > q.size()) return 16'hDEAD;
        for (int i = 0; i < nb; i++) w = {w[14:0], q[pos+i][0]};
        return w;
    endfunction

    // 0: all dc low, 1: all dc high, 2: mixed within the unit
    function automatic logic [1:0] dcs(input logic [1:0] q [$], input int pos, input int nb);
        int ones = 0;
        if (pos + nb > q.size()) return 2'd3;
        for (int i = 0; i < nb; i++) ones += int'(q[pos+i][1]);
        return (ones == 0) ? 2'd0 : (ones == nb) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [15:0] exp_px(input logic [15:0] d);
`ifdef POTATO_LCD_RGB_SWAP_EN
        return {d[4:0], d[10:5], d[15:11]};
`else
        return d;
`endif
    endfunction

    task automatic run_frame(output logic [1:0] q [$]);
        int n = 0, c0;
        cap.delete();
        c0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!done && n < 5000) begin @(negedge clk); n++; end
        check("frame_done_timeout", 32'(n < 5000), 32'd1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("frame_done_width", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        check("idle_after_frame", {30'd0, busy, cs_n}, 32'd1);
        check("frame_done_pulses", 32'(done_cnt - c0), 32'd1);
        q = cap;
    endtask

    typedef struct {
        string       name;
        int          frame;
        int          pos;
        int          nb;
        logic [15:0] exp;
        logic        exp_dc;
    } vec_t;

    vec_t        vt [17];
    logic [7:0]  cb  [11] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
    logic        cdc [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] pxv [4]  = '{16'h00A5, 16'h01A5, 16'h10A5, 16'h11A5};
    logic [1:0]  f0 [$], f1 [$], f2 [$];

    initial begin
        for (int i = 0; i < 11; i++) vt[i] = '{$sformatf("cmd%0d", i), 0, 8*i, 8, {8'h00, cb[i]}, cdc[i]};
        for (int p = 0; p < 4; p++) vt[11+p] = '{$sformatf("pix%0d", p), 0, 88 + 16*p, 16, exp_px(pxv[p]), 1'b1};
        vt[15] = '{"swap_pix0", 1, 88, 16, exp_px(16'hF800), 1'b1};
        vt[16] = '{"swap_pix3", 1, 136, 16, exp_px(16'hF800), 1'b1};

        rst_n = 1'b0; start = 1'b0; pat = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, cs_n, sclk, mosi, dc, busy, done}, 32'b100000);
        check("rst_addr", {16'd0, ax, ay}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", {30'd0, busy, cs_n}, 32'd1);

        run_frame(f0);
        check("frame0_bits", 32'(f0.size()), 32'd152);
        pat = 1'b1;
        run_frame(f1);
        check("frame1_bits", 32'(f1.size()), 32'd152);
        pat = 1'b0;

        for (int i = 0; i < 17; i++) begin
            logic [1:0] q [$];
            q = (vt[i].frame == 0) ? f0 : f1;
            check(vt[i].name, {16'd0, dec(q, vt[i].pos, vt[i].nb)}, {16'd0, vt[i].exp});
            check({vt[i].name, "_dc"}, {30'd0, dcs(q, vt[i].pos, vt[i].nb)}, {31'd0, vt[i].exp_dc});
        end

        // Abort mid-pixel-1, then a clean frame must start over from 2A and (0,0)
        begin
            int n = 0;
            cap.delete();
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            while (cap.size() < 112 && n < 5000) begin @(negedge clk); n++; end
            check("midframe_timeout", 32'(n < 5000), 32'd1);
            check("midframe_addr_x", {24'd0, ax}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("abort_outputs", {29'd0, cs_n, sclk, busy}, 32'b100);
            check("abort_addr", {16'd0, ax, ay}, 32'd0);
            @(negedge clk) rst_n = 1'b1;
            run_frame(f2);
            check("restart_bits", 32'(f2.size()), 32'd152);
            check("restart_cmd0", {16'd0, dec(f2, 0, 8)}, 32'h2A);
            check("restart_pix0", {16'd0, dec(f2, 88, 16)}, {16'd0, exp_px(16'h00A5)});
        end

        // Free-running instance: cs_n gap between back-to-back frames
        repeat (2000) @(negedge clk);
        check("cont_frames", 32'(c_done_cnt >= 2), 32'd1);
        check("cont_gap_seen", 32'(c_gaps.size() >= 1), 32'd1);
        foreach (c_gaps[i]) check($sformatf("cont_gap%0d", i), 32'(c_gaps[i]), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
